// File: rtl/avalon_interval_timer.sv
// Avalon-MM interval timer: programmable period, start/stop, one-shot or continuous.
// Define INTERVAL_TIMER_SNAPSHOT_EN to add the SNAPL/SNAPH counter capture registers.
module avalon_interval_timer #(
    parameter int          COUNTER_WIDTH = 32,
    parameter logic [31:0] RESET_PERIOD  = 32'h0001869F,
    parameter bit          RESET_RUNNING = 1'b1,
    parameter bit          RESET_CONT    = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq
);

    localparam int CW = COUNTER_WIDTH;
    localparam logic [CW-1:0] RST_PERIOD = RESET_PERIOD[CW-1:0];

    logic [CW-1:0] period;
    logic [CW-1:0] counter;
    logic          run;
    logic          run_next;
    logic          cont;
    logic          ito;
    logic          to;
    logic          force_reload;
    logic          timeout_event;
    logic [15:0]   rd_mux;

    logic wr_en;
    logic wr_status;
    logic wr_control;
    logic wr_periodl;
    logic wr_periodh;

    assign wr_en      = chipselect & ~write_n;
    assign wr_status  = wr_en & (address == 3'd0);
    assign wr_control = wr_en & (address == 3'd1);
    assign wr_periodl = wr_en & (address == 3'd2);
    assign wr_periodh = wr_en & (address == 3'd3);

    assign timeout_event = run & (counter == '0);
    assign irq = to & ito;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period       <= RST_PERIOD;
            force_reload <= 1'b0;
        end else begin
            if (wr_periodl)
                period[15:0] <= writedata;
            if (wr_periodh)
                period[CW-1:16] <= writedata[CW-17:0];
            force_reload <= wr_periodl | wr_periodh;
        end
    end

    // A pending period write outranks the natural reload and the decrement.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            counter <= RST_PERIOD;
        else if (force_reload || timeout_event)
            counter <= period;
        else if (run)
            counter <= counter - CW'(1);
    end

    always_comb begin
        run_next = run;
        if (timeout_event && !cont)
            run_next = 1'b0;
        if (wr_control && writedata[2])
            run_next = 1'b1;
        if (wr_control && writedata[3])
            run_next = 1'b0;
        if (wr_periodl || wr_periodh)
            run_next = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run  <= RESET_RUNNING;
            cont <= RESET_CONT;
            ito  <= 1'b0;
        end else begin
            run <= run_next;
            if (wr_control) begin
                ito  <= writedata[0];
                cont <= writedata[1];
            end
        end
    end

    // The event wins over a clearing STATUS write on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            to <= 1'b0;
        else if (timeout_event)
            to <= 1'b1;
        else if (wr_status)
            to <= 1'b0;
    end

`ifdef INTERVAL_TIMER_SNAPSHOT_EN
    logic [CW-1:0] snapshot;
    logic          wr_snapl;

    assign wr_snapl = wr_en & (address == 3'd4);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            snapshot <= '0;
        else if (wr_snapl)
            snapshot <= counter;
    end
`endif

    always_comb begin
        rd_mux = 16'h0000;
        case (address)
            3'd0:    rd_mux = {14'b0, run, to};
            3'd1:    rd_mux = {14'b0, cont, ito};
            3'd2:    rd_mux = period[15:0];
            3'd3:    rd_mux = 16'(period[CW-1:16]);
`ifdef INTERVAL_TIMER_SNAPSHOT_EN
            3'd4:    rd_mux = snapshot[15:0];
            3'd5:    rd_mux = 16'(snapshot[CW-1:16]);
`endif
            default: rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            readdata <= 16'h0000;
        else
            readdata <= rd_mux;
    end

endmodule

// File: tb/tb_avalon_interval_timer.sv
// Directed self-checking bench for avalon_interval_timer.
// Drives and samples on the falling edge; one task per scenario.
module tb_avalon_interval_timer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = 16'h0000;
    logic [15:0] readdata;
    logic        irq;

    int errors = 0;
    int checks = 0;

    avalon_interval_timer #(
        .COUNTER_WIDTH(32),
        .RESET_PERIOD (32'd999),
        .RESET_RUNNING(1'b1),
        .RESET_CONT   (1'b1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One write, taking effect at the next rising edge.
    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        cyc(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [15:0] d);
        address = a;
        cyc(1);
        d = readdata;
    endtask

    task automatic test_reset;
        logic [15:0] d;
        cyc(2);
        checks++;
        if (readdata !== 16'h0000) begin
            errors++;
            $display("FAIL reset_readdata got=%h exp=0000", readdata);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq got=%b exp=0", irq);
        end
        reset_n = 1'b1;
        address = 3'd0;
        cyc(1);
        checks++;
        if (readdata !== 16'h0002) begin
            errors++;
            $display("FAIL reset_status got=%h exp=0002", readdata);
        end
        cyc(999);
        checks++;
        if (readdata !== 16'h0002) begin
            errors++;
            $display("FAIL pre_timeout_status got=%h exp=0002", readdata);
        end
        cyc(1);
        d = readdata;
        checks++;
        if (d !== 16'h0003) begin
            errors++;
            $display("FAIL first_timeout_status got=%h exp=0003", d);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_masked got=%b exp=0", irq);
        end
    endtask

    task automatic test_continuous;
        wr(3'd2, 16'd9);
        wr(3'd3, 16'd0);
        wr(3'd0, 16'd0);
        wr(3'd1, 16'h0007);
        cyc(9);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL cont_irq_early got=%b exp=0", irq);
        end
        cyc(1);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL cont_irq_first got=%b exp=1", irq);
        end
        cyc(4);
        wr(3'd0, 16'd0);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL cont_irq_clear got=%b exp=0", irq);
        end
        cyc(4);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL cont_irq_second_early got=%b exp=0", irq);
        end
        cyc(1);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL cont_irq_second got=%b exp=1", irq);
        end
    endtask

    task automatic test_one_shot;
        logic [15:0] d;
        wr(3'd2, 16'd4);
        wr(3'd3, 16'd0);
        wr(3'd0, 16'd0);
        wr(3'd1, 16'h0005);
        cyc(4);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_irq_early got=%b exp=0", irq);
        end
        cyc(1);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_irq got=%b exp=1", irq);
        end
        rd(3'd0, d);
        checks++;
        if (d !== 16'h0001) begin
            errors++;
            $display("FAIL oneshot_status got=%h exp=0001", d);
        end
        wr(3'd0, 16'd0);
        cyc(12);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_no_retrigger got=%b exp=0", irq);
        end
        // Counter must have held at 4: restart gives another 5-clock interval.
        wr(3'd1, 16'h0005);
        cyc(4);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_hold_early got=%b exp=0", irq);
        end
        cyc(1);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_hold got=%b exp=1", irq);
        end
    endtask

    task automatic test_same_edge_and_stop;
        logic [15:0] d;
        wr(3'd0, 16'd0);
        wr(3'd1, 16'h0007);
        cyc(4);
        wr(3'd0, 16'd0);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL same_edge_to got=%b exp=1", irq);
        end
        wr(3'd1, 16'h000C);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL stop_ito_cleared got=%b exp=0", irq);
        end
        rd(3'd0, d);
        checks++;
        if (d !== 16'h0001) begin
            errors++;
            $display("FAIL stop_wins_status got=%h exp=0001", d);
        end
    endtask

    task automatic test_periodh_write;
        logic [15:0] d;
        wr(3'd0, 16'd0);
        wr(3'd1, 16'h0007);
        wr(3'd3, 16'h0000);
        cyc(20);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL periodh_no_timeout got=%b exp=0", irq);
        end
        rd(3'd0, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL periodh_run_clear got=%h exp=0000", d);
        end
        wr(3'd1, 16'h0007);
        cyc(4);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL periodh_reload_early got=%b exp=0", irq);
        end
        cyc(1);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL periodh_reload got=%b exp=1", irq);
        end
    endtask

    task automatic test_snapshot;
        logic [15:0] d;
        wr(3'd2, 16'h2345);
        wr(3'd3, 16'h0001);
        wr(3'd1, 16'h0006);
        rd(3'd2, d);
        checks++;
        if (d !== 16'h2345) begin
            errors++;
            $display("FAIL periodl_read got=%h exp=2345", d);
        end
        rd(3'd3, d);
        checks++;
        if (d !== 16'h0001) begin
            errors++;
            $display("FAIL periodh_read got=%h exp=0001", d);
        end
        cyc(3);
        // Counter was 0x12345 after the CONTROL write; five edges later it is 0x12340.
        wr(3'd4, 16'h0000);
        rd(3'd4, d);
`ifdef INTERVAL_TIMER_SNAPSHOT_EN
        checks++;
        if (d !== 16'h2340) begin
            errors++;
            $display("FAIL snapl got=%h exp=2340", d);
        end
        rd(3'd5, d);
        checks++;
        if (d !== 16'h0001) begin
            errors++;
            $display("FAIL snaph got=%h exp=0001", d);
        end
`else
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL snapl_absent got=%h exp=0000", d);
        end
        rd(3'd5, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL snaph_absent got=%h exp=0000", d);
        end
`endif
        wr(3'd6, 16'hFFFF);
        rd(3'd6, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL addr6 got=%h exp=0000", d);
        end
    endtask

    task automatic test_reset_mid_count;
        logic [15:0] d;
        wr(3'd1, 16'h0003);
        cyc(2);
        reset_n = 1'b0;
        #1;
        checks++;
        if (readdata !== 16'h0000 || irq !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs got=%h/%b exp=0000/0", readdata, irq);
        end
        cyc(2);
        reset_n = 1'b1;
        rd(3'd1, d);
        checks++;
        if (d !== 16'h0002) begin
            errors++;
            $display("FAIL midreset_control got=%h exp=0002", d);
        end
        rd(3'd2, d);
        checks++;
        if (d !== 16'd999) begin
            errors++;
            $display("FAIL midreset_period got=%h exp=03e7", d);
        end
    endtask

    initial begin
        test_reset;
        test_continuous;
        test_one_shot;
        test_same_edge_and_stop;
        test_periodh_write;
        test_snapshot;
        test_reset_mid_count;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/avalon_interval_timer.md
Name: avalon_interval_timer

Overview:
- Parametrised successor to the fixed-period system clock timer: programmable period, selectable width, start/stop control, one-shot or continuous mode.
- 16-bit Avalon-MM slave with one-cycle registered read latency. Level interrupt to the Nios II IRQ input.
- Used as system tick, timeout and delay source in the SD/TFT designs.

Parameters:
- COUNTER_WIDTH, 32, down-counter width. Legal range 17..32. Period bits above COUNTER_WIDTH are ignored on write and read as 0.
- RESET_PERIOD, 32'h0001869F, period and counter value after reset. Truncated to COUNTER_WIDTH.
- RESET_RUNNING, 1, counter runs from reset when 1; stopped when 0.
- RESET_CONT, 1, reset value of the CONT control bit.

Ports:
- clk  in  1  system clock; all logic is synchronous to its rising edge.
- reset_n  in  1  reset; asynchronous assert, active-low.
- address  in  3  register word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  16  write data.
- readdata  out  16  registered read data. Reset value 0.
- irq  out  1  interrupt, level, active-high. Reset value 0.

Behaviour:
- Register map:
  - 0 STATUS: bit0 TO, bit1 RUN (read-only). Any write clears TO.
  - 1 CONTROL: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP. START and STOP are write-only pulses and read as 0.
  - 2 PERIODL: period[15:0].
  - 3 PERIODH: period[COUNTER_WIDTH-1:16].
  - 4 SNAPL, 5 SNAPH: see Optional Feature.
  - 6, 7: read 0; writes ignored.
- Write strobe: chipselect & ~write_n & address match. A write takes effect at the clock edge on which it is presented.
- Read path: readdata <= mux(address) every clock, regardless of chipselect. Data is valid on the cycle after the address is presented.
- Reset state:
  - period = counter = RESET_PERIOD; RUN = RESET_RUNNING; CONT = RESET_CONT.
  - ITO = 0; TO = 0; snapshot = 0.
- Counting:
  - While RUN is set: counter decrements by 1 per clock.
  - When RUN is set and counter == 0: counter reloads period next cycle and a one-cycle timeout_event fires.
  - Timeout interval is period+1 clocks.
  - If CONT = 0 at the timeout_event, RUN clears on the same edge (one-shot). The counter still reloads to period.
  - While RUN is clear, the counter holds its value.
- PERIODL/PERIODH write:
  - Updates that half of the period.
  - Clears RUN.
  - Sets force_reload; on the next edge, counter <= new period.
  - To restart, software writes START.
- CONTROL write:
  - ITO and CONT are latched from writedata.
  - START=1: RUN <= 1.
  - STOP=1: RUN <= 0.
  - START and STOP both 1: STOP wins.
  - START while already running does not reload the counter.
- TO sets on timeout_event. A STATUS write on the same edge as timeout_event leaves TO set (event wins).
- irq = TO & ITO, decoded from registers only; no combinational path from the bus.
- period = 0 with RUN set: a timeout_event fires every clock and TO stays set. Legal.
- Counter wraps only via reload, never through underflow.
- Reset mid-count: all state returns to reset values immediately; no pending event survives.

Optional Feature:
- Macro: INTERVAL_TIMER_SNAPSHOT_EN.
- Defined:
  - Any write to SNAPL captures the live counter into a COUNTER_WIDTH snapshot register on that edge.
  - SNAPL reads snapshot[15:0]; SNAPH reads snapshot[COUNTER_WIDTH-1:16], zero-extended.
  - Writes to SNAPH are ignored.
  - Counting is not disturbed by a capture.
- Not defined: no snapshot register; addresses 4/5 read 0 and writes are ignored.

Test Plan:
- Reset, read STATUS -> readdata 0x0002 one cycle after the address; irq 0. Count 100000 clocks -> TO = 1 at the cycle after counter reaches 0.
- Write PERIODL=9, PERIODH=0, CONTROL=0x0007 (ITO, CONT, START) -> TO and irq rise every 10 clocks. Write STATUS mid-interval -> irq drops the next cycle.
- CONTROL=0x0005 (one-shot), period 4 -> exactly one timeout after 5 clocks; then STATUS reads 0x0001 (RUN = 0) and the counter holds 4.
- STATUS write on the same edge as timeout_event -> TO remains 1. CONTROL=0x000C -> RUN = 0 (STOP wins).
- PERIODH write while running -> RUN = 0; counter equals the new period two cycles later. No timeout occurs until START is written.
- With INTERVAL_TIMER_SNAPSHOT_EN, period 0x00012345, write SNAPL at a known counter value N -> SNAPL/SNAPH read N[15:0]/N[31:16]. Without the macro -> addresses 4 and 5 read 0x0000.
